// File: rtl/axi_lite_master_cmd.sv
// -----------------------------------------------------------------------------
// axi_lite_master_cmd
//   Single-outstanding AXI4-Lite master. A command presented on the
//   valid/ready command port becomes exactly one AXI4-Lite read or write.
//   The slave's BRESP/RRESP (and read data) is returned on the valid/ready
//   response port. No new command is accepted until that response has been
//   taken. DATA_WIDTH is expected to be 32 or 64.
//
// Ports
//   aclk, aresetn             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata/wstrb command payload, captured on acceptance
//   rsp_valid/rsp_ready       response handshake
//   rsp_write/rdata/resp      response payload (rdata is 0 for writes)
//   aw*/w*/b*/ar*/r*          AXI4-Lite master channels; prot is always 0
//
// Every AXI valid/ready output comes straight from a flop, so there is no
// combinational path from an AXI input to an AXI output.
// -----------------------------------------------------------------------------
module axi_lite_master_cmd #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AW channel
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  // W channel
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  // B channel
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  // AR channel
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  // R channel
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_t;

  state_t                state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  write_q,     write_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic                  awvalid_q,   awvalid_d;
  logic                  wvalid_q,    wvalid_d;
  logic                  aw_done_q,   aw_done_d;
  logic                  w_done_q,    w_done_d;
  logic                  bready_q,    bready_d;
  logic                  arvalid_q,   arvalid_d;
  logic                  rready_q,    rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q,  rsp_resp_d;

  logic aw_hs_s;
  logic w_hs_s;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    aw_hs_s = awvalid_q & awready;
    w_hs_s  = wvalid_q & wready;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cmd_ready_d = 1'b0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (cmd_write) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      // AW and W complete independently; the done flags remember which
      // channel has already handshaken so neither is re-issued.
      ST_WRITE: begin
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end else begin
          wvalid_d = wvalid_q;
        end
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_WRESP: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = bresp;
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
          state_d     = ST_RSP;
        end else begin
          state_d = ST_WRESP;
        end
      end

      ST_RADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end else begin
          state_d = ST_RADDR;
        end
      end

      ST_RDATA: begin
        if (rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_resp_d  = rresp;
          rsp_rdata_d = rdata;
          state_d     = ST_RSP;
        end else begin
          state_d = ST_RDATA;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end

      // Unreachable encodings recover to a quiet IDLE.
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      write_q     <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      wstrb_q     <= {STRB_WIDTH{1'b0}};
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  // The captured address serves both AW and AR; only one is ever valid.
  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awprot  = 3'b000;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arprot  = 3'b000;
  assign rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_cmd
//   Directed bench for axi_lite_master_cmd. The slave side is driven cycle by
//   cycle from the main sequence. A small memory model backs the
//   back-to-back write/read case. Outputs are sampled 1 time unit after the
//   rising edge, and inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_cmd;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  logic        mem_mode;
  logic [31:0] rdata_drv;
  logic [31:0] mem [0:15];

  int n_cmp = 0;
  int n_err = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;
  int b_hs_cnt = 0;
  int rsp_hs_cnt = 0;

  axi_lite_master_cmd #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arprot    (arprot),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp)
  );

  // Read data comes either from the memory model or from a directed value.
  assign rdata = mem_mode ? mem[araddr[5:2]] : rdata_drv;

  // Clock generator.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Handshake counters and memory model updated on the active edge.
  always @(posedge aclk) begin
    if (awvalid && awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (wvalid && wready) begin
      w_hs_cnt <= w_hs_cnt + 1;
      mem[awaddr[5:2]] <= wdata;
    end
    if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = 4'hF;
  endtask

  // One write where AW and W readies pulse at chosen cycles after T0.
  task automatic write_skew(input int aw_dly, input int w_dly, input logic [31:0] addr);
    int a0, w0, b0, r0, last;
    a0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; r0 = rsp_hs_cnt;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    issue(1'b1, addr, 32'h1111_0000 + addr);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c <= last; c++) begin
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      tick();
      if (c < aw_dly) begin
        chk("skew_awvalid_hold", {63'd0, awvalid}, 64'd1);
        chk("skew_awaddr_hold", {32'd0, awaddr}, {32'd0, addr});
      end
      if (c < w_dly) chk("skew_wvalid_hold", {63'd0, wvalid}, 64'd1);
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("skew_bready", {63'd0, bready}, 64'd1);
    chk("skew_valids_low", {62'd0, awvalid, wvalid}, 64'd0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("skew_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("skew_rsp_write", {63'd0, rsp_write}, 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("skew_aw_once", 64'(aw_hs_cnt - a0), 64'd1);
    chk("skew_w_once", 64'(w_hs_cnt - w0), 64'd1);
    chk("skew_b_once", 64'(b_hs_cnt - b0), 64'd1);
    chk("skew_rsp_once", 64'(rsp_hs_cnt - r0), 64'd1);
  endtask

  initial begin
    int r0;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
    cmd_wdata = 32'd0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    mem_mode = 1'b0; rdata_drv = 32'd0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_valids", {59'd0, rsp_valid, awvalid, wvalid, arvalid, 1'b0}, 64'd0);
    chk("rst_readys", {62'd0, bready, rready}, 64'd0);
    chk("rst_rsp_payload", {29'd0, rsp_write, rsp_resp, rsp_rdata}, 64'd0);
    aresetn = 1'b1;
    tick();

    // ---- minimum-latency write; bvalid held early must be ignored ----
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    issue(1'b1, 32'h8, 32'hDEAD_BEEF);
    tick();                                   // T0 accepted
    cmd_valid = 1'b0;
    chk("w1_t1_aw_w_valid", {62'd0, awvalid, wvalid}, 64'd3);
    chk("w1_t1_awaddr", {32'd0, awaddr}, 64'h8);
    chk("w1_t1_wdata", {28'd0, wstrb, wdata}, 64'hF_DEAD_BEEF);
    chk("w1_t1_prot", {58'd0, awprot, arprot}, 64'd0);
    chk("w1_t1_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("w1_t1_bready", {63'd0, bready}, 64'd0);
    tick();                                   // T1 AW/W handshakes
    chk("w1_t2_bready", {63'd0, bready}, 64'd1);
    chk("w1_t2_valids", {62'd0, awvalid, wvalid}, 64'd0);
    tick();                                   // T2 B handshake
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    chk("w1_t3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("w1_t3_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, 1'b1, 2'b00, 32'd0});
    chk("w1_t3_bready", {63'd0, bready}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w1_done", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // ---- read with 4-cycle arready delay ----
    issue(1'b0, 32'h8, 32'd0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("r1_arvalid_hold", {63'd0, arvalid}, 64'd1);
      chk("r1_araddr_hold", {32'd0, araddr}, 64'h8);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("r1_ar_done", {62'd0, arvalid, rready}, 64'd1);
    rvalid = 1'b1; rdata_drv = 32'hDEAD_BEEF; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk("r1_rsp_valid", {62'd0, rsp_valid, rready}, 64'd2);
    chk("r1_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, 64'h0_DEAD_BEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("r1_done", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // ---- AW/W ordering: W first, AW first, same cycle ----
    write_skew(3, 0, 32'h10);
    write_skew(0, 3, 32'h14);
    write_skew(0, 0, 32'h18);

    // ---- SLVERR read with response back-pressure ----
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata_drv = 32'h1234_5678;
    issue(1'b0, 32'h20, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    arready = 1'b0; rvalid = 1'b0;
    chk("r2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r2_hold_valid", {62'd0, rsp_valid, cmd_ready}, 64'd2);
      chk("r2_hold_payload", {29'd0, rsp_write, rsp_resp, rsp_rdata}, 64'h2_1234_5678);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("r2_done", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // ---- back-to-back write 0x4, read 0x4, write 0xC ----
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; mem_mode = 1'b1;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h4, 32'hA5A5_0004);
    tick();                                   // write accepted
    issue(1'b0, 32'h4, 32'd0);
    tick(); tick();
    chk("b2b_w_rsp", {61'd0, rsp_valid, rsp_write, cmd_ready}, 64'd6);
    tick();                                   // rsp handshake
    chk("b2b_ready_again", {62'd0, rsp_valid, cmd_ready}, 64'd1);
    tick();                                   // read accepted
    chk("b2b_r_accept", {62'd0, arvalid, cmd_ready}, 64'd2);
    issue(1'b1, 32'hC, 32'h0000_C0DE);
    tick(); tick();
    chk("b2b_r_rsp", {31'd0, rsp_valid, rsp_rdata}, 64'h1_A5A5_0004);
    tick();
    chk("b2b_ready_again2", {63'd0, cmd_ready}, 64'd1);
    tick();                                   // write 0xC accepted
    cmd_valid = 1'b0;
    chk("b2b_w2_accept", {31'd0, awvalid, awaddr}, 64'h1_0000_000C);
    tick(); tick();
    chk("b2b_w2_rsp", {62'd0, rsp_valid, rsp_write}, 64'd3);
    tick();
    rsp_ready = 1'b0; mem_mode = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    chk("b2b_mem_c", {32'd0, mem[3]}, 64'h0000_C0DE);

    // ---- reset mid-write ----
    r0 = rsp_hs_cnt;
    issue(1'b1, 32'h24, 32'h5555_AAAA);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_mid_awvalid", {62'd0, awvalid, wvalid}, 64'd3);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_drop", {61'd0, awvalid, wvalid, rsp_valid}, 64'd0);
    chk("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    tick();
    aresetn = 1'b1;
    tick();
    chk("rst_mid_no_rsp", {61'd0, rsp_valid, bready, 1'b0}, 64'd0);
    chk("rst_mid_rsp_cnt", 64'(rsp_hs_cnt - r0), 64'd0);
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; rdata_drv = 32'h0BAD_F00D;
    issue(1'b0, 32'h8, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    arready = 1'b0; rvalid = 1'b0;
    chk("rst_after_read", {29'd0, rsp_valid, rsp_resp, rsp_rdata}, 64'h4_0BAD_F00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rst_after_done", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
